// File: rtl/icache_line_fetcher_pkg.sv
// Shared constants for the line-based instruction fetcher: truth values,
// instruction width, refill FSM encoding and address-field width helpers.
package icache_line_fetcher_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int DATA_WIDTH = 32;
  // Byte offset inside a 32-bit word; instructions are word aligned.
  localparam int BYTE_OFF_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    DRAIN  = 2'd2
  } fetch_state_t;

  // Number of address bits taken by a field holding n entries (0 when n==1).
  function automatic int field_w(input int n);
    return (n > 1) ? $clog2(n) : 0;
  endfunction

  // Width of an index into an n-entry array; never narrower than one bit.
  function automatic int index_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// Tag/valid/data storage of the direct-mapped instruction cache.
// Read side is combinational (zero-latency hit); write side offers a line
// allocate port (new tag, valid cleared), a per-word data port, a line
// validate strobe and a whole-cache invalidate.
module icache_line_array
  import icache_line_fetcher_pkg::*;
#(
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4,
  parameter int TAG_W      = 24,
  parameter int IDX_W      = 4,
  parameter int OFF_B      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  // lookup
  input  logic [IDX_W-1:0]      rd_idx,
  input  logic [OFF_B-1:0]      rd_off,
  input  logic [TAG_W-1:0]      rd_tag,
  output logic                  rd_hit,
  output logic [DATA_WIDTH-1:0] rd_data,
  // line allocate: write tag, drop valid so a partial line never hits
  input  logic                  alloc_we,
  input  logic [IDX_W-1:0]      alloc_idx,
  input  logic [TAG_W-1:0]      alloc_tag,
  // per-word refill write and line completion
  input  logic                  word_we,
  input  logic [IDX_W-1:0]      word_idx,
  input  logic [OFF_B-1:0]      word_off,
  input  logic [DATA_WIDTH-1:0] word_data,
  input  logic                  line_valid_we,
  // clear every valid bit; wins over line completion in the same cycle
  input  logic                  invalidate_all
);

  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]      tags     [NUM_LINES];
  logic [DATA_WIDTH-1:0] data_mem [NUM_LINES][LINE_WORDS];

  // Valid bits: reset/invalidate clear all, allocate clears one, completion sets one.
  always_ff @(posedge clk) begin
    if (rst || invalidate_all) begin
      valid <= '0;
    end else begin
      if (alloc_we) valid[alloc_idx] <= FALSE;
      if (line_valid_we) valid[word_idx] <= TRUE;
    end
  end

  // Tag store, written when a refill starts.
  always_ff @(posedge clk) begin
    if (alloc_we) tags[alloc_idx] <= alloc_tag;
  end

  // Data store, one word per refill response.
  always_ff @(posedge clk) begin
    if (word_we) data_mem[word_idx][word_off] <= word_data;
  end

  // Combinational lookup; data reads as zero on a miss.
  always_comb begin
    rd_hit  = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    rd_data = '0;
    if (rd_hit) rd_data = data_mem[rd_idx][rd_off];
  end

endmodule

// File: rtl/icache_line_fetcher.sv
// Instruction fetch unit with a direct-mapped, multi-word-line I-cache.
// Hits deliver in the same cycle; a miss refills the whole line one word at a
// time, and a flush or invalidate during refill drains the outstanding request.
//
// Memory handshake: out_mem_ena is a one-cycle request pulse carrying
// out_address; in_mem_ready is a one-cycle response strobe carrying
// in_mem_inst. At most one request is outstanding, so the next pulse is only
// issued in the cycle after the previous response has been accepted.
module icache_line_fetcher
  import icache_line_fetcher_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int NUM_LINES  = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [ADDR_W-1:0]     in_pc,
  input  logic                  in_flush,
  input  logic                  in_invalidate,
  input  logic                  in_result_taken,
  output logic [ADDR_W-1:0]     out_pc_query,
  output logic                  out_pc_reg_ena,
  output logic                  out_decoder_ena,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic [ADDR_W-1:0]     out_decoder_pc,
  output logic                  out_branch_taken,
  output logic                  out_mem_ena,
  output logic [ADDR_W-1:0]     out_address,
  input  logic                  in_mem_ready,
  input  logic [DATA_WIDTH-1:0] in_mem_inst
);

  localparam int OFF_W = field_w(LINE_WORDS);
  localparam int IDX_W = field_w(NUM_LINES);
  localparam int OFF_B = index_w(LINE_WORDS);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W - BYTE_OFF_W;
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS * 4 - 1);
  localparam logic [OFF_B-1:0]  LAST_WORD = OFF_B'(LINE_WORDS - 1);

  fetch_state_t      state;
  logic [ADDR_W-1:0] base;
  logic [OFF_B-1:0]  word_cnt;

  logic [OFF_B-1:0]      pc_off;
  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [IDX_W-1:0]      base_idx;
  logic                  hit;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  miss_start;
  logic                  refill_abort;
  logic                  word_we;
  logic                  line_done;
  logic [ADDR_W-1:0]     next_address;

  // Address split, lookup qualification and FSM strobes.
  always_comb begin
    pc_off       = OFF_B'((in_pc >> BYTE_OFF_W) & ADDR_W'(LINE_WORDS - 1));
    pc_idx       = IDX_W'(in_pc >> (OFF_W + BYTE_OFF_W));
    pc_tag       = TAG_W'(in_pc >> (IDX_W + OFF_W + BYTE_OFF_W));
    base_idx     = IDX_W'(base >> (OFF_W + BYTE_OFF_W));
    miss_start   = (state == IDLE) && ena && !hit && !in_flush && !in_invalidate;
    refill_abort = (state == REFILL) && (in_flush || in_invalidate);
    word_we      = (state == REFILL) && in_mem_ready && !refill_abort;
    line_done    = word_we && (word_cnt == LAST_WORD);
    // OR keeps the address inside the line, so the top line needs no special case.
    next_address = base | (ADDR_W'(word_cnt + OFF_B'(1)) << BYTE_OFF_W);
  end

  // Decoder-facing outputs: zero-latency delivery, PC advances only on delivery.
  always_comb begin
    out_pc_query     = in_pc;
    out_decoder_ena  = ena && hit && (state == IDLE) && !in_flush;
    out_pc_reg_ena   = out_decoder_ena;
    out_inst         = rd_data;
    out_decoder_pc   = in_pc;
    out_branch_taken = in_result_taken;
  end

  icache_line_array #(
    .NUM_LINES (NUM_LINES),
    .LINE_WORDS(LINE_WORDS),
    .TAG_W     (TAG_W),
    .IDX_W     (IDX_W),
    .OFF_B     (OFF_B)
  ) u_array (
    .clk           (clk),
    .rst           (rst),
    .rd_idx        (pc_idx),
    .rd_off        (pc_off),
    .rd_tag        (pc_tag),
    .rd_hit        (hit),
    .rd_data       (rd_data),
    .alloc_we      (miss_start),
    .alloc_idx     (pc_idx),
    .alloc_tag     (pc_tag),
    .word_we       (word_we),
    .word_idx      (base_idx),
    .word_off      (word_cnt),
    .word_data     (in_mem_inst),
    .line_valid_we (line_done),
    .invalidate_all(in_invalidate)
  );

  // Refill FSM with registered memory request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      base        <= '0;
      word_cnt    <= '0;
      out_mem_ena <= FALSE;
      out_address <= '0;
    end else begin
      out_mem_ena <= FALSE;
      case (state)
        IDLE: begin
          if (miss_start) begin
            state       <= REFILL;
            base        <= in_pc & LINE_MASK;
            word_cnt    <= '0;
            out_mem_ena <= TRUE;
            out_address <= in_pc & LINE_MASK;
          end
        end
        REFILL: begin
          if (refill_abort) begin
            // A response in the abort cycle retires the request; nothing left to drain.
            state <= in_mem_ready ? IDLE : DRAIN;
          end else if (in_mem_ready) begin
            if (word_cnt == LAST_WORD) begin
              state <= IDLE;
            end else begin
              word_cnt    <= word_cnt + OFF_B'(1);
              out_mem_ena <= TRUE;
              out_address <= next_address;
            end
          end
        end
        DRAIN: begin
          if (in_mem_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
